// File: rtl/id_ex_stage.sv
// ID/EX pipeline register.
// Captures decode-stage operands, immediate, PC, destination and control,
// and presents them to execute one cycle later. A write-back bypass covers
// the same-cycle register-file write/read hazard, both on capture and while
// the stage is held by a stall. Load-use hazards are detected here and
// answered with a bubble. A saturating counter records stalled cycles.
//
// Ports:
//   CLK, RESET                 clock, asynchronous active-high reset
//   STALL, FLUSH               hold EX contents / insert a bubble
//   ID_*                       decode-slot instruction fields
//   WB_*                       write-back port (same strobe as the register file)
//   EX_*                       registered fields for execute
//   LOAD_USE_STALL             combinational load-use hazard flag
//   STALL_CYCLES               saturating count of stalled cycles
module id_ex_stage #(
  parameter int unsigned CTRL_W        = 8,
  parameter int unsigned MEM_READ_BIT  = 0,
  parameter int unsigned REG_WRITE_BIT = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              STALL,
  input  logic              FLUSH,
  input  logic              ID_VALID,
  input  logic [63:0]       ID_PC,
  input  logic [4:0]        ID_READ_REG_A,
  input  logic [4:0]        ID_READ_REG_B,
  input  logic [63:0]       ID_DATA_A,
  input  logic [63:0]       ID_DATA_B,
  input  logic [63:0]       ID_IMM,
  input  logic [4:0]        ID_DEST_REG,
  input  logic [CTRL_W-1:0] ID_CTRL,
  input  logic              WB_REG_WRITE_ENABLE,
  input  logic [4:0]        WB_WRITE_REG,
  input  logic [63:0]       WB_WRITE_DATA,
  output logic              EX_VALID,
  output logic [63:0]       EX_PC,
  output logic [63:0]       EX_DATA_A,
  output logic [63:0]       EX_DATA_B,
  output logic [63:0]       EX_IMM,
  output logic [4:0]        EX_READ_REG_A,
  output logic [4:0]        EX_READ_REG_B,
  output logic [4:0]        EX_DEST_REG,
  output logic [CTRL_W-1:0] EX_CTRL,
  output logic              LOAD_USE_STALL,
  output logic [31:0]       STALL_CYCLES
);

  logic              r_valid;
  logic [63:0]       r_pc;
  logic [63:0]       r_data_a;
  logic [63:0]       r_data_b;
  logic [63:0]       r_imm;
  logic [4:0]        r_read_reg_a;
  logic [4:0]        r_read_reg_b;
  logic [4:0]        r_dest_reg;
  logic [CTRL_W-1:0] r_ctrl;
  logic [31:0]       r_stall_cycles;

  logic              w_wb_live;
  logic [63:0]       w_a_byp;
  logic [63:0]       w_b_byp;
  logic              w_load_use;
  logic              w_count;

  // Register 0 never receives a write, so it is excluded from every match.
  assign w_wb_live = WB_REG_WRITE_ENABLE && (WB_WRITE_REG != 5'd0);

  assign w_a_byp = (w_wb_live && (WB_WRITE_REG == ID_READ_REG_A)) ? WB_WRITE_DATA : ID_DATA_A;
  assign w_b_byp = (w_wb_live && (WB_WRITE_REG == ID_READ_REG_B)) ? WB_WRITE_DATA : ID_DATA_B;

  assign w_load_use = r_valid && r_ctrl[MEM_READ_BIT] && (r_dest_reg != 5'd0) && ID_VALID &&
                      ((r_dest_reg == ID_READ_REG_A) || (r_dest_reg == ID_READ_REG_B));

  // A flush discards the cycle, so it is not counted as a stall.
  assign w_count = (STALL || w_load_use) && !FLUSH;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_data_a     <= '0;
      r_data_b     <= '0;
      r_imm        <= '0;
      r_read_reg_a <= '0;
      r_read_reg_b <= '0;
      r_dest_reg   <= '0;
      r_ctrl       <= '0;
    end else if (STALL && !FLUSH) begin
      // Hold, but keep held operands coherent with write-back.
      if (w_wb_live && (WB_WRITE_REG == r_read_reg_a)) r_data_a <= WB_WRITE_DATA;
      if (w_wb_live && (WB_WRITE_REG == r_read_reg_b)) r_data_b <= WB_WRITE_DATA;
    end else begin
      // Flush, load-use bubble and normal load all capture the ID fields;
      // bubbles only differ in valid/control.
      r_pc         <= ID_PC;
      r_data_a     <= w_a_byp;
      r_data_b     <= w_b_byp;
      r_imm        <= ID_IMM;
      r_read_reg_a <= ID_READ_REG_A;
      r_read_reg_b <= ID_READ_REG_B;
      r_dest_reg   <= ID_DEST_REG;
      if (FLUSH || w_load_use) begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
      end else begin
        r_valid <= ID_VALID;
        r_ctrl  <= ID_VALID ? ID_CTRL : '0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_stall_cycles <= '0;
    end else if (w_count && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign EX_VALID       = r_valid;
  assign EX_PC          = r_pc;
  assign EX_DATA_A      = r_data_a;
  assign EX_DATA_B      = r_data_b;
  assign EX_IMM         = r_imm;
  assign EX_READ_REG_A  = r_read_reg_a;
  assign EX_READ_REG_B  = r_read_reg_b;
  assign EX_DEST_REG    = r_dest_reg;
  assign EX_CTRL        = r_ctrl;
  assign LOAD_USE_STALL = w_load_use;
  assign STALL_CYCLES   = r_stall_cycles;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly downstream of the register file.
- Captures the register-file read data, immediate, PC, destination and control for the instruction in decode, and presents them to execute one cycle later.
- Closes the write-back/read same-cycle hazard with a WB bypass, including while the stage is held by a stall.
- Detects load-use hazards, inserts bubbles for them, and keeps a saturating stall-cycle counter.

Parameters:
- CTRL_W, 8, width of the decoded control bundle.
- MEM_READ_BIT, 0, index within the control bundle of the memory-read (load) flag.
- REG_WRITE_BIT, 1, index within the control bundle of the register-write flag.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-high reset.
- STALL  input  1  hold the current EX contents.
- FLUSH  input  1  replace the next EX contents with a bubble.
- ID_VALID  input  1  decode slot holds a real instruction.
- ID_PC  input  64  PC of the decode instruction.
- ID_READ_REG_A  input  5  source register A index.
- ID_READ_REG_B  input  5  source register B index.
- ID_DATA_A  input  64  register-file read data for A.
- ID_DATA_B  input  64  register-file read data for B.
- ID_IMM  input  64  sign-extended immediate.
- ID_DEST_REG  input  5  destination register index.
- ID_CTRL  input  CTRL_W  decoded control bundle.
- WB_REG_WRITE_ENABLE  input  1  write-back write strobe (same signal that drives the register file).
- WB_WRITE_REG  input  5  write-back destination register.
- WB_WRITE_DATA  input  64  write-back data.
- EX_VALID  output  1  EX slot holds a real instruction.
- EX_PC  output  64  registered PC.
- EX_DATA_A  output  64  registered operand A.
- EX_DATA_B  output  64  registered operand B.
- EX_IMM  output  64  registered immediate.
- EX_READ_REG_A  output  5  registered source index A, used by forwarding.
- EX_READ_REG_B  output  5  registered source index B, used by forwarding.
- EX_DEST_REG  output  5  registered destination index.
- EX_CTRL  output  CTRL_W  registered control bundle.
- LOAD_USE_STALL  output  1  combinational load-use hazard flag.
- STALL_CYCLES  output  32  saturating count of cycles spent stalled.

Behaviour:
- Reset: RESET high forces every registered output to 0 immediately, without waiting for CLK.
- Register 0 is hardwired zero. It is never a bypass target and never a hazard source.
- Bypass (combinational, on the ID inputs):
  - A_byp = WB_WRITE_DATA when WB_REG_WRITE_ENABLE=1, WB_WRITE_REG==ID_READ_REG_A and ID_READ_REG_A!=0; otherwise ID_DATA_A.
  - B_byp is defined identically for B.
- LOAD_USE_STALL = EX_VALID & EX_CTRL[MEM_READ_BIT] & EX_DEST_REG!=0 & ID_VALID & (EX_DEST_REG==ID_READ_REG_A | EX_DEST_REG==ID_READ_REG_B).
- Posedge update, highest priority first:
  1. FLUSH=1: insert a bubble. EX_VALID=0 and EX_CTRL=0; the other fields take the ID values (don't-care, but deterministic).
  2. STALL=1: hold every field, with one exception. If WB_REG_WRITE_ENABLE=1, WB_WRITE_REG!=0 and WB_WRITE_REG==EX_READ_REG_A, EX_DATA_A is refreshed to WB_WRITE_DATA. The same rule applies to B. This keeps a held operand from going stale.
  3. LOAD_USE_STALL=1: insert a bubble, as in case 1. The hazard unit holds IF/ID externally.
  4. Otherwise load: EX_VALID=ID_VALID, EX_DATA_A=A_byp, EX_DATA_B=B_byp, and all remaining fields come directly from their ID_ counterparts.
- ID_VALID=0 on a load: the fields are captured as usual, but EX_CTRL is forced to 0.
- Latency: exactly 1 cycle from ID inputs to EX outputs when no stall or flush is active.
- STALL_CYCLES:
  - Increments by 1 on each posedge where STALL=1 or LOAD_USE_STALL=1 and FLUSH=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by RESET.
- Reset mid-operation: in-flight contents are lost; the first posedge after RESET falls behaves as a normal load.

Test Plan:
- Reset: assert RESET between clock edges with EX_VALID=1 and EX_DATA_A=0x55 -> all EX outputs read 0 before the next posedge; STALL_CYCLES=0.
- Basic load: ID_READ_REG_A=3, ID_DATA_A=0x10, ID_VALID=1, no WB write -> EX_DATA_A=0x10 and EX_VALID=1 after one edge.
- Same-cycle bypass: ID_READ_REG_B=5, ID_DATA_B=0x1, with WB writing reg 5 = 0xABCD -> EX_DATA_B=0xABCD.
- Register 0: WB writing reg 0 = 0x99 with ID_READ_REG_A=0 and ID_DATA_A=0 -> EX_DATA_A=0.
- Stall refresh: EX_READ_REG_A=7 and EX_DATA_A=0x2; assert STALL with WB writing reg 7 = 0x77 -> EX_DATA_A=0x77 and every other field unchanged.
- Load-use: EX holds a load to reg 4; ID instruction reads reg 4 -> LOAD_USE_STALL=1 and the next EX_VALID=0. With FLUSH and STALL both high -> bubble. STALL_CYCLES increments only for the load-use cycle, not the flush cycle.
